dispatcher: RTL
===============

Name: dispatcher

Overview:
- Sits between instruction decode and the execution pipes (ALU, LSU).
- Consumes the registered id_dispatcher_inf_t bundle, reads operands from an internal 32x32 register file and tracks in-flight destination registers in a scoreboard.
- Issues the instruction to the pipe selected by exe_pipe, or raises stall to freeze fetch/decode on RAW/WAW hazards or LSU back-pressure.
- Owns architectural register writeback from both pipes.

Parameters:
- NUM_REGS, 32, architectural registers; x0 hardwired zero.
- XLEN, 32, data width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- flush  in  1  squash the decode-side instruction and the current dispatch output
- id_dispatcher_inf  in  id_dispatcher_inf_t  decoded instruction; bubble when exe_pipe == 0
- lsu_ready  in  1  LSU can accept an instruction this cycle
- alu_wb_en / alu_wb_rd / alu_wb_data  in  1/5/XLEN  ALU writeback
- lsu_wb_en / lsu_wb_rd / lsu_wb_data  in  1/5/XLEN  LSU writeback
- stall  out  1  hazard; core holds IF and ID
- dispatcher_exe_inf  out  dispatcher_exe_inf_t  ctrl, rs1_data, rs2_data, rd, imm_ext, pc, pc_inc
- alu_valid  out  1  dispatcher_exe_inf valid for ALU
- lsu_valid  out  1  dispatcher_exe_inf valid for LSU

Behaviour:
- Reset (rst low, async): alu_valid = lsu_valid = 0; scoreboard all clear; register file all zero; dispatcher_exe_inf all zero. stall is combinational and reads 0 while in reset.
- Input valid: in_v = |exe_pipe.
- Pending bits:
  - pend[r] is the scoreboard bit for register r.
  - clr[r] = (alu_wb_en && alu_wb_rd == r) || (lsu_wb_en && lsu_wb_rd == r).
  - busy[r] = pend[r] && !clr[r]. busy[0] is always 0.
- Hazard (combinational):
  - in_v && (busy[a1] || busy[a2] || (register_write && busy[rd]) || (exe_pipe LSU bit && !lsu_ready)).
  - stall = hazard && !flush.
- Dispatch fires when in_v && !hazard && !flush. Latency is one cycle: the outputs register at the next edge.
  - alu_valid is set from the exe_pipe ALU bit and lsu_valid from the LSU bit. Both bits set is illegal; assert.
  - On a non-dispatch cycle both valids go to 0. Payload holds its value, don't-care.
- Operand read:
  - Combinational regfile read with write-first bypass: a same-cycle writeback to a1/a2 is forwarded.
  - Index 0 reads 0.
  - If both writebacks target the same rd in one cycle, the LSU wins; assert this never happens.
- Scoreboard update each cycle:
  - pend &= ~clr.
  - On dispatch with register_write && rd != 0: set pend[rd].
  - Set beats clear for the same index in the same cycle (new producer).
- Flush:
  - Forces alu_valid = lsu_valid = 0 next cycle; the decode-side instruction is dropped.
  - If the output register currently holds a valid instruction with register_write, clear its pend bit (it will never write back).
  - Writebacks arriving in the flush cycle still commit and clear.
- Regfile write: on each wb_en with rd != 0 at clk edge. Writes to x0 are ignored.
- Back-pressure is LSU only; the ALU always accepts. A held instruction waits indefinitely on lsu_ready.
- Reset mid-operation discards everything; no writeback is committed after reset asserts.

Decomposition:
- Package (defines.svh):
  - dispatcher_exe_inf_t struct.
  - EXE_PIPE_ALU_BIT / EXE_PIPE_LSU_BIT (existing).
  - NUM_REGS.
- Sub-module register_file: 2 read ports, 2 write ports, write-first bypass, x0 zero, async active-low reset. Scoreboard and hazard logic stay in dispatcher.

Test Plan:
- ADDI x1,x0,5 then ADD x2,x1,x1 back-to-back, ALU writeback of x1 = 5 two cycles after dispatch -> stall = 1 until the wb cycle; ADD dispatches in the wb cycle with rs1_data = rs2_data = 5 via bypass.
- LW x3 with lsu_ready = 0 for 3 cycles -> stall = 1 for 3 cycles, lsu_valid = 0; lsu_ready = 1 -> lsu_valid = 1 next edge, pend[3] = 1.
- WAW: LW x4 in flight, ADDI x4,x0,1 -> stall until lsu_wb_rd = 4; then dispatches and pend[4] stays 1.
- Flush while output holds ADDI x5 (alu_valid = 1) and decode holds ADD x6 -> next cycle alu_valid = 0, pend[5] = pend[6] = 0, stall = 0.
- Writes to x0: ADDI x0,x0,7 -> no pend bit set, no stall on a following read of x0, rs1_data = 0.
- Async reset asserted mid-stall with pend[1] = 1 -> immediately alu_valid = lsu_valid = 0, stall = 0, scoreboard clear, x1 reads 0 after release.

Source files
------------

// File: rtl/dispatcher_pkg.sv
// Shared types and constants for the dispatch stage: decode/execute bundles,
// pipe-select bit positions and a register-index mask helper.
package dispatcher_pkg;

    localparam int XLEN             = 32;
    localparam int NUM_REGS         = 32;
    localparam int REG_AW           = $clog2(NUM_REGS);
    localparam int EXE_PIPE_W       = 2;
    localparam int EXE_PIPE_ALU_BIT = 0;
    localparam int EXE_PIPE_LSU_BIT = 1;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_SLT,
        ALU_SLTU,
        ALU_PASS_B
    } alu_op_e;

    typedef struct packed {
        alu_op_e               alu_op;
        logic                  alu_src_imm;
        logic                  mem_read;
        logic                  mem_write;
        logic [2:0]            mem_size;
        logic                  register_write;
        logic [EXE_PIPE_W-1:0] exe_pipe;
    } ctrl_t;

    typedef struct packed {
        ctrl_t             ctrl;
        logic [REG_AW-1:0] a1;
        logic [REG_AW-1:0] a2;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   imm_ext;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   pc_inc;
    } id_dispatcher_inf_t;

    typedef struct packed {
        ctrl_t             ctrl;
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   imm_ext;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   pc_inc;
    } dispatcher_exe_inf_t;

    // One-hot register mask; x0 never produces a bit since it is never pending.
    function automatic logic [NUM_REGS-1:0] reg_mask(input logic [REG_AW-1:0] idx);
        reg_mask      = '0;
        reg_mask[idx] = (idx != '0);
    endfunction

endpackage

// File: rtl/dispatcher_if.sv
// Decode-side, writeback and execute-side signals of the dispatcher bundled
// into one interface; the dispatcher uses the slave view.
interface dispatcher_if;
    import dispatcher_pkg::*;

    logic                flush;
    id_dispatcher_inf_t  id_dispatcher_inf;
    logic                lsu_ready;
    logic                alu_wb_en;
    logic [REG_AW-1:0]   alu_wb_rd;
    logic [XLEN-1:0]     alu_wb_data;
    logic                lsu_wb_en;
    logic [REG_AW-1:0]   lsu_wb_rd;
    logic [XLEN-1:0]     lsu_wb_data;
    logic                stall;
    dispatcher_exe_inf_t dispatcher_exe_inf;
    logic                alu_valid;
    logic                lsu_valid;

    modport master (
        output flush, id_dispatcher_inf, lsu_ready,
        output alu_wb_en, alu_wb_rd, alu_wb_data,
        output lsu_wb_en, lsu_wb_rd, lsu_wb_data,
        input  stall, dispatcher_exe_inf, alu_valid, lsu_valid
    );

    modport slave (
        input  flush, id_dispatcher_inf, lsu_ready,
        input  alu_wb_en, alu_wb_rd, alu_wb_data,
        input  lsu_wb_en, lsu_wb_rd, lsu_wb_data,
        output stall, dispatcher_exe_inf, alu_valid, lsu_valid
    );

endinterface

// File: rtl/dispatcher_register_file.sv
// Architectural register file: two combinational read ports with write-first
// bypass, two write ports (port B = LSU, wins on a same-index collision), x0 zero.
module dispatcher_register_file
    import dispatcher_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] rd_addr_a,
    input  logic [REG_AW-1:0] rd_addr_b,
    output logic [XLEN-1:0]   rd_data_a,
    output logic [XLEN-1:0]   rd_data_b,
    input  logic              wr_en_a,
    input  logic [REG_AW-1:0] wr_addr_a,
    input  logic [XLEN-1:0]   wr_data_a,
    input  logic              wr_en_b,
    input  logic [REG_AW-1:0] wr_addr_b,
    input  logic [XLEN-1:0]   wr_data_b
);

    logic [XLEN-1:0] regs [NUM_REGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (wr_en_a && wr_addr_a != '0) begin
                regs[wr_addr_a] <= wr_data_a;
            end
            if (wr_en_b && wr_addr_b != '0) begin
                regs[wr_addr_b] <= wr_data_b;
            end
        end
    end

    // Later assignment wins, so a port-B write shadows a port-A write to the same index.
    always_comb begin
        rd_data_a = regs[rd_addr_a];
        if (wr_en_a && wr_addr_a == rd_addr_a) begin
            rd_data_a = wr_data_a;
        end
        if (wr_en_b && wr_addr_b == rd_addr_a) begin
            rd_data_a = wr_data_b;
        end
        if (rd_addr_a == '0) begin
            rd_data_a = '0;
        end
    end

    always_comb begin
        rd_data_b = regs[rd_addr_b];
        if (wr_en_a && wr_addr_a == rd_addr_b) begin
            rd_data_b = wr_data_a;
        end
        if (wr_en_b && wr_addr_b == rd_addr_b) begin
            rd_data_b = wr_data_b;
        end
        if (rd_addr_b == '0) begin
            rd_data_b = '0;
        end
    end

    wb_collision_a : assert property (@(posedge clk) disable iff (!rst_n)
        !(wr_en_a && wr_en_b && wr_addr_a == wr_addr_b && wr_addr_a != '0));

endmodule

// File: rtl/dispatcher.sv
// Dispatch stage: operand read, scoreboard of in-flight destinations, hazard
// stall generation and a one-cycle registered issue to the ALU or LSU pipe.
module dispatcher
    import dispatcher_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    dispatcher_if.slave bus
);

    id_dispatcher_inf_t  id;
    dispatcher_exe_inf_t out_q;
    logic                alu_valid_q;
    logic                lsu_valid_q;

    logic [NUM_REGS-1:0] pend;
    logic [NUM_REGS-1:0] pend_next;
    logic [NUM_REGS-1:0] clr;
    logic [NUM_REGS-1:0] busy;

    logic                in_v;
    logic                is_alu;
    logic                is_lsu;
    logic                hazard;
    logic                fire;
    logic [XLEN-1:0]     rs1_val;
    logic [XLEN-1:0]     rs2_val;

    assign id     = bus.id_dispatcher_inf;
    assign in_v   = |id.ctrl.exe_pipe;
    assign is_alu = id.ctrl.exe_pipe[EXE_PIPE_ALU_BIT];
    assign is_lsu = id.ctrl.exe_pipe[EXE_PIPE_LSU_BIT];

    // A writeback landing this cycle releases its register immediately.
    assign clr  = (bus.alu_wb_en ? reg_mask(bus.alu_wb_rd) : '0)
                | (bus.lsu_wb_en ? reg_mask(bus.lsu_wb_rd) : '0);
    assign busy = pend & ~clr & ~reg_mask('0);

    always_comb begin
        hazard = 1'b0;
        if (in_v) begin
            hazard = busy[id.a1] || busy[id.a2]
                  || (id.ctrl.register_write && busy[id.rd])
                  || (is_lsu && !bus.lsu_ready);
        end
    end

    assign fire      = in_v && !hazard && !bus.flush;
    assign bus.stall = hazard && !bus.flush && rst_n;

    dispatcher_register_file u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_addr_a (id.a1),
        .rd_addr_b (id.a2),
        .rd_data_a (rs1_val),
        .rd_data_b (rs2_val),
        .wr_en_a   (bus.alu_wb_en),
        .wr_addr_a (bus.alu_wb_rd),
        .wr_data_a (bus.alu_wb_data),
        .wr_en_b   (bus.lsu_wb_en),
        .wr_addr_b (bus.lsu_wb_rd),
        .wr_data_b (bus.lsu_wb_data)
    );

    // A flushed issue never executes, so its destination must be released here.
    always_comb begin
        pend_next = pend & ~clr;
        if (bus.flush && (alu_valid_q || lsu_valid_q) && out_q.ctrl.register_write) begin
            pend_next = pend_next & ~reg_mask(out_q.rd);
        end
        if (fire && id.ctrl.register_write) begin
            pend_next = pend_next | reg_mask(id.rd);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend        <= '0;
            alu_valid_q <= 1'b0;
            lsu_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            pend        <= pend_next;
            alu_valid_q <= fire && is_alu;
            lsu_valid_q <= fire && is_lsu;
            if (fire) begin
                out_q <= '{ctrl:     id.ctrl,
                           rs1_data: rs1_val,
                           rs2_data: rs2_val,
                           rd:       id.rd,
                           imm_ext:  id.imm_ext,
                           pc:       id.pc,
                           pc_inc:   id.pc_inc};
            end
        end
    end

    assign bus.dispatcher_exe_inf = out_q;
    assign bus.alu_valid          = alu_valid_q;
    assign bus.lsu_valid          = lsu_valid_q;

    single_pipe_a : assert property (@(posedge clk) disable iff (!rst_n)
        !(is_alu && is_lsu));

endmodule
